// File: rtl/floppy_step_ctrl.sv
// Floppy head stepper controller: debounced host steps, one-deep step queue, settle timer, track-0 recal.
// Optional STEP_HALF_EN macro selects half-step coil sequencing (intermediate phase held for HALF_DWELL cycles).
module floppy_step_ctrl #(
    parameter int DEBOUNCE_CYC = 8,
    parameter int SETTLE_CYC   = 30000,
    parameter int MAX_TRACK    = 79,
    parameter int TRK_W        = 7,
    parameter int HALF_DWELL   = 5000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             drive_sel_n_i,
    input  logic             step_n_i,
    input  logic             dir_n_i,
    input  logic             t00_sens_i,
    output logic [3:0]       step_drv_o,
    output logic             track_0_n_o,
    output logic [TRK_W-1:0] track_o,
    output logic             busy_o,
    output logic             step_ovf_o
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam int TMR_W = $clog2(SETTLE_CYC + HALF_DWELL + 1);

`ifdef STEP_HALF_EN
    localparam int PH_W = 3;
    typedef enum logic [2:0] {IDLE, MOVE_A, DWELL, MOVE, SETTLE} state_t;
    localparam state_t FIRST_MOVE = MOVE_A;
`else
    localparam int PH_W = 2;
    typedef enum logic [1:0] {IDLE, MOVE, SETTLE} state_t;
    localparam state_t FIRST_MOVE = MOVE;
`endif

    logic [1:0]       step_sync_q, dir_sync_q, sel_sync_q, t00_sync_q;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [PH_W-1:0]  ph_q, ph_d, ph_step;
    logic [TRK_W-1:0] track_q, track_d;
    state_t           state_q, state_d;
    logic             cur_dir_q, cur_dir_d;
    logic             q_full_q, q_full_d, q_dir_q, q_dir_d;
    logic             ovf_q, ovf_d, t0n_q;
    logic             step_s, step_rise, sel_s, dir_s, t00_s;
    logic             accept, can_move, last_settle;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            step_sync_q <= 2'b11;
            dir_sync_q  <= 2'b11;
            sel_sync_q  <= 2'b11;
            t00_sync_q  <= 2'b00;
        end else begin
            step_sync_q <= {step_sync_q[0], step_n_i};
            dir_sync_q  <= {dir_sync_q[0], dir_n_i};
            sel_sync_q  <= {sel_sync_q[0], drive_sel_n_i};
            t00_sync_q  <= {t00_sync_q[0], t00_sens_i};
        end
    end

    assign step_s    = step_sync_q[1];
    assign step_rise = step_sync_q[0] & ~step_sync_q[1];
    assign sel_s     = ~sel_sync_q[1];
    assign dir_s     = dir_sync_q[1];
    assign t00_s     = t00_sync_q[1];

    // Terminal count is judged on the next value so the current low cycle counts toward the minimum.
    always_comb begin
        db_cnt_d = db_cnt_q;
        if (step_s || !sel_s)
            db_cnt_d = DB_W'(DEBOUNCE_CYC);
        else if (db_cnt_q != '0)
            db_cnt_d = db_cnt_q - DB_W'(1);
    end

    assign accept      = step_rise & sel_s & (db_cnt_d == '0);
    assign can_move    = cur_dir_q ? (track_q != '0) : (track_q != TRK_W'(MAX_TRACK));
    assign ph_step     = cur_dir_q ? ph_q - PH_W'(1) : ph_q + PH_W'(1);
    assign last_settle = (state_q == SETTLE) && (tmr_q == '0);

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        ph_d      = ph_q;
        track_d   = track_q;
        cur_dir_d = cur_dir_q;
        q_full_d  = q_full_q;
        q_dir_d   = q_dir_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cur_dir_d = dir_s;
                    state_d   = FIRST_MOVE;
                end
            end
`ifdef STEP_HALF_EN
            MOVE_A: begin
                if (can_move) ph_d = ph_step;
                tmr_d   = TMR_W'(HALF_DWELL - 2);
                state_d = DWELL;
            end
            DWELL: begin
                if (tmr_q == '0) state_d = MOVE;
                else             tmr_d   = tmr_q - TMR_W'(1);
            end
`endif
            MOVE: begin
                if (can_move) begin
                    ph_d    = ph_step;
                    track_d = cur_dir_q ? track_q - TRK_W'(1) : track_q + TRK_W'(1);
                end
                if (cur_dir_q && t00_s) track_d = '0;
                tmr_d   = TMR_W'(SETTLE_CYC - 1);
                state_d = SETTLE;
            end
            SETTLE: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else if (q_full_q) begin
                    cur_dir_d = q_dir_q;
                    q_full_d  = 1'b0;
                    state_d   = FIRST_MOVE;
                end else if (accept) begin
                    cur_dir_d = dir_s;
                    state_d   = FIRST_MOVE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A step arriving while busy refills the slot the final settle cycle just drained.
        if (accept && state_q != IDLE) begin
            if (last_settle) begin
                if (q_full_q) begin
                    q_full_d = 1'b1;
                    q_dir_d  = dir_s;
                end
            end else if (q_full_q) begin
                ovf_d = 1'b1;
            end else begin
                q_full_d = 1'b1;
                q_dir_d  = dir_s;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            db_cnt_q  <= DB_W'(DEBOUNCE_CYC);
            tmr_q     <= '0;
            ph_q      <= '0;
            track_q   <= '0;
            cur_dir_q <= 1'b0;
            q_full_q  <= 1'b0;
            q_dir_q   <= 1'b0;
            ovf_q     <= 1'b0;
            t0n_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            db_cnt_q  <= db_cnt_d;
            tmr_q     <= tmr_d;
            ph_q      <= ph_d;
            track_q   <= track_d;
            cur_dir_q <= cur_dir_d;
            q_full_q  <= q_full_d;
            q_dir_q   <= q_dir_d;
            ovf_q     <= ovf_d;
            t0n_q     <= ~(sel_s & t00_s);
        end
    end

`ifdef STEP_HALF_EN
    always_comb begin
        case (ph_q)
            3'd0:    step_drv_o = 4'b0001;
            3'd1:    step_drv_o = 4'b0011;
            3'd2:    step_drv_o = 4'b0010;
            3'd3:    step_drv_o = 4'b0110;
            3'd4:    step_drv_o = 4'b0100;
            3'd5:    step_drv_o = 4'b1100;
            3'd6:    step_drv_o = 4'b1000;
            default: step_drv_o = 4'b1001;
        endcase
    end
`else
    assign step_drv_o = 4'b0001 << ph_q;
`endif

    assign track_0_n_o = t0n_q;
    assign track_o     = track_q;
    assign busy_o      = (state_q != IDLE);
    assign step_ovf_o  = ovf_q;

endmodule

// File: tb/tb_floppy_step_ctrl.sv
// Bench for floppy_step_ctrl: directed cases plus random steps against an abstract track/phase model.
module tb_floppy_step_ctrl;
    localparam int D = 8, S = 200, MAXT = 5, TW = 7, HD = 6;
`ifdef STEP_HALF_EN
    localparam int EXTRA = HD;
`else
    localparam int EXTRA = 0;
`endif

    logic          clk = 1'b0;
    logic          rst, drive_sel_n, step_n, dir_n, t00_sens;
    logic [3:0]    step_drv;
    logic          track_0_n, busy, step_ovf;
    logic [TW-1:0] track;

    int n_tests = 0, n_fail = 0;
    int m_track = 0, m_ph = 0, m_ovf = 0;
    bit m_sel = 1'b1, m_t00 = 1'b0;

    floppy_step_ctrl #(.DEBOUNCE_CYC(D), .SETTLE_CYC(S), .MAX_TRACK(MAXT), .TRK_W(TW), .HALF_DWELL(HD)) dut (
        .clk_i(clk), .rst_i(rst), .drive_sel_n_i(drive_sel_n), .step_n_i(step_n), .dir_n_i(dir_n),
        .t00_sens_i(t00_sens), .step_drv_o(step_drv), .track_0_n_o(track_0_n), .track_o(track),
        .busy_o(busy), .step_ovf_o(step_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_track"}, track, m_track);
        check({tag, "_drv"}, step_drv, 4'b0001 << m_ph);
        check({tag, "_t0n"}, track_0_n, !(m_sel && m_t00));
    endtask

    // A valid step moves one track/phase unless at an end stop; outward with sensor lit means track 0.
    task automatic model_step(input bit outward, input int width);
        if (m_sel && width >= D) begin
            if (outward) begin
                if (m_track > 0) begin
                    m_track--;
                    m_ph = (m_ph + 3) % 4;
                end
                if (m_t00) m_track = 0;
            end else if (m_track < MAXT) begin
                m_track++;
                m_ph = (m_ph + 1) % 4;
            end
        end
    endtask

    task automatic pulse(input bit outward, input int width);
        dir_n  = outward;
        step_n = 1'b0;
        repeat (width) @(posedge clk);
        #1 step_n = 1'b1;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        tick(4);
        for (int i = 0; i < 4000; i++) begin
            if (!busy) break;
            tick(1);
            cyc++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic do_step(input bit outward, input int width, output int cyc);
        pulse(outward, width);
        model_step(outward, width);
        wait_idle(cyc);
    endtask

    initial begin
        int cyc, cnt, w;
        bit d;
        rst = 1'b1; step_n = 1'b1; dir_n = 1'b0; drive_sel_n = 1'b0; t00_sens = 1'b0;
        tick(3);
        check_state("reset");
        check("reset_busy", busy, 0);
        check("reset_ovf", step_ovf, 0);
        rst = 1'b0;
        tick(4);

        // too-short pulse is ignored
        pulse(1'b0, 2);
        model_step(1'b0, 2);
        tick(10);
        check_state("short");
        check("short_busy", busy, 0);

        // single inward step: latency, phase and busy length
        pulse(1'b0, 20);
        model_step(1'b0, 20);
        tick(2);
        check("lat_pre_drv", step_drv, 4'b0001);
        check("lat_busy", busy, 1);
        cnt = 1;
        for (int k = 0; k < S + HD + 50; k++) begin
            tick(1);
`ifdef STEP_HALF_EN
            if (k == 0) check("half_mid_drv", step_drv, 4'b0011);
            if (k == HD - 1) check("half_dwell_drv", step_drv, 4'b0011);
            if (k == HD) begin
                check("half_end_drv", step_drv, 4'b0010);
                check("half_trk", track, 1);
            end
`else
            if (k == 0) begin
                check("lat_drv", step_drv, 4'b0010);
                check("lat_trk", track, 1);
            end
`endif
            if (!busy) break;
            cnt++;
        end
        check("busy_len", cnt, S + 1 + EXTRA);
        check_state("step1");

        // deselected drive ignores steps and masks the track-0 pin
        drive_sel_n = 1'b1; m_sel = 1'b0; t00_sens = 1'b1; m_t00 = 1'b1;
        tick(4);
        do_step(1'b0, 20, cyc);
        check_state("desel");
        drive_sel_n = 1'b0; m_sel = 1'b1;
        tick(4);
        check("resel_t0n", track_0_n, 0);
        t00_sens = 1'b0; m_t00 = 1'b0;
        tick(4);

        // three steps during one settle: second queued, third dropped
        check("ovf_clear", step_ovf, 0);
        pulse(1'b0, 20); model_step(1'b0, 20); tick(30);
        pulse(1'b0, 20); model_step(1'b0, 20); tick(30);
        pulse(1'b0, 20); m_ovf = 1;
        wait_idle(cyc);
        check_state("queue");
        check("queue_ovf", step_ovf, m_ovf);

        // recalibration on outward step with sensor lit, then outward at track 0
        t00_sens = 1'b1; m_t00 = 1'b1;
        tick(4);
        do_step(1'b1, 20, cyc);
        check_state("recal");
        do_step(1'b1, 20, cyc);
        check_state("recal_stop");
        t00_sens = 1'b0; m_t00 = 1'b0;
        tick(4);

        // inward end stop still passes through settle
        for (int i = 0; i < MAXT; i++) do_step(1'b0, 20, cyc);
        check_state("to_max");
        do_step(1'b0, 20, cyc);
        check("endstop_settle", cyc, S - 1 + EXTRA);
        check_state("endstop");

        // debounce boundary
        do_step(1'b1, D - 1, cyc);
        check_state("db_short");
        do_step(1'b1, D, cyc);
        check_state("db_exact");

        for (int i = 0; i < 30; i++) begin
            m_sel = ($urandom_range(0, 4) != 0);
            drive_sel_n = !m_sel;
            m_t00 = ($urandom_range(0, 3) == 0);
            t00_sens = m_t00;
            tick(4);
            w = $urandom_range(1, 20);
            d = 1'($urandom_range(0, 1));
            do_step(d, w, cyc);
            check_state("rnd");
        end
        check("ovf_sticky", step_ovf, m_ovf);

        // reset in the middle of settle
        drive_sel_n = 1'b0; m_sel = 1'b1; t00_sens = 1'b0; m_t00 = 1'b0;
        tick(4);
        pulse(1'b1, 20);
        tick(30);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        m_track = 0; m_ph = 0; m_ovf = 0;
        check_state("midrst");
        check("midrst_busy", busy, 0);
        check("midrst_ovf", step_ovf, m_ovf);
        tick(2);
        rst = 1'b0;
        tick(4);
        check("post_rst_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/floppy_step_ctrl.md
Name: floppy_step_ctrl

Overview:
- Parametrised head-positioning controller for the floppy drive emulator; successor to the fixed 4-coil step logic in the controller circuit.
- Takes host STEP/DIR/drive-select from the 34-pin interface and drives a 4-coil stepper through ULN2003-style outputs.
- Adds configurable debounce, a head-settle interval with a one-deep step queue, track bookkeeping with end stops, and track-0 recalibration.

Parameters:
- DEBOUNCE_CYC, 8: minimum synced low cycles on step_n for a pulse to count as a step.
- SETTLE_CYC, 30000: cycles the head is busy after each move (3 ms at 10 MHz).
- MAX_TRACK, 79: highest legal track.
- TRK_W, 7: width of the track counter.
- HALF_DWELL, 5000: dwell on the intermediate half-step phase. Used only with STEP_HALF_EN.

Ports:
- clk, in, 1: system clock (10 MHz).
- rst, in, 1: asynchronous reset, active-high.
- drive_sel_n, in, 1: this drive selected. Active low.
- step_n, in, 1: host step pulse. Active low.
- dir_n, in, 1: direction. 0 = inward (track+1), 1 = outward (track-1).
- t00_sens, in, 1: track-0 optical sensor. Active high.
- step_drv, out, 4: coil drive, one-hot in full-step mode.
- track_0_n, out, 1: interface pin 26. Active low.
- track, out, TRK_W: current logical track.
- busy, out, 1: move or settle in progress.
- step_ovf, out, 1: sticky flag; a step was dropped.

Behaviour:
- Reset values: step_drv=0001, track=0, busy=0, track_0_n=1, step_ovf=0, FSM=IDLE, queue empty.
- Input synchronisers: step_n, dir_n, drive_sel_n and t00_sens each pass through a 2-flop synchroniser. All logic below uses the synced values.
- track_0_n = 0 only when drive selected AND synced t00_sens=1; otherwise 1. Registered output.
- Step qualification:
  - Debounce counter runs while synced step_n=0 and the drive is selected. It saturates at DEBOUNCE_CYC.
  - A step is accepted on the synced rising edge of step_n only if the counter reached DEBOUNCE_CYC. Direction is sampled at that edge. Shorter pulses are ignored.
  - The counter clears when step_n is high.
- FSM states:
  - IDLE: an accepted step goes to MOVE.
  - MOVE: lasts 1 cycle. Updates phase and track, then goes to SETTLE. Sets busy=1.
  - SETTLE: counts SETTLE_CYC cycles. If the queue is full, goes to MOVE; otherwise goes to IDLE and clears busy.
- Phase rotation:
  - Inward: 0001→0010→0100→1000→0001.
  - Outward: the reverse of inward.
  - step_drv changes on the clock edge ending MOVE. This is 3 clocks after the raw step_n rises (2 sync + 1 FSM).
- Track arithmetic:
  - Inward at track=MAX_TRACK: no phase change, track unchanged, still passes through SETTLE.
  - Outward at track=0: no phase change.
  - Otherwise track moves ±1.
- Recalibration: after any outward MOVE, if synced t00_sens=1, track is forced to 0 regardless of its count.
- Queue:
  - A step accepted while busy is stored, together with its direction, in a one-deep queue.
  - A further step accepted while the queue is full is dropped and sets step_ovf.
  - step_ovf clears only on rst.
- Deselect during debounce: the counter is cleared and the pulse is ignored.
- Deselect during MOVE/SETTLE: the current move completes, and the queued step is still executed.
- Simultaneous step acceptance at the final SETTLE cycle: the step goes to the queue, so MOVE follows immediately. No step is lost.
- rst mid-settle: the FSM returns to IDLE immediately, with all outputs at their reset values.

Optional Feature:
- Macro: STEP_HALF_EN.
- Defined: half-step sequence 0001,0011,0010,0110,0100,1100,1000,1001.
  - Each host step is two half-steps: MOVE_A enters the intermediate phase, waits HALF_DWELL cycles, then MOVE_B enters the next full phase and starts SETTLE.
  - busy covers the dwell as well.
  - Track changes at MOVE_B.
  - The reset phase remains 0001.
- Undefined: full-step only. There is no MOVE_A state, and HALF_DWELL is unused.

Test Plan:
- Selected, step_n low 2 cycles then high → step_drv stays 0001, track=0, busy=0.
- Selected, dir_n=0, step_n low 20 cycles then released → step_drv=0010 and track=1 within 3 clocks of release; busy high for SETTLE_CYC cycles.
- Deselected, valid 20-cycle step → step_drv=0001 unchanged; track_0_n=1 with t00_sens=1. Reselect → track_0_n=0.
- Three valid inward steps 50 cycles apart from track 0 → two MOVEs executed back-to-back (track=2, step_drv=0100), step_ovf=1.
- track=3, t00_sens=1, one outward step → track=0, step_drv back one phase; further outward step → phase unchanged, track=0.
- STEP_HALF_EN defined, one inward step → step_drv=0011 for HALF_DWELL cycles, then 0010, track=1.
